// File: rtl/upload_pkg.sv
// Shared definitions for the upload arbiter: FSM state encoding and the
// source-ID byte that each peripheral handler stamps on its upload beats.
package upload_pkg;

    localparam int UPLOAD_SRC_W = 8;

    localparam logic [UPLOAD_SRC_W-1:0] SRC_UART = 8'h01;
    localparam logic [UPLOAD_SRC_W-1:0] SRC_SPI  = 8'h02;
    localparam logic [UPLOAD_SRC_W-1:0] SRC_DSM  = 8'h03;
    localparam logic [UPLOAD_SRC_W-1:0] SRC_I2C  = 8'h04;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN,
        GAP
    } arb_state_e;

endpackage

// File: rtl/upload_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first set request bit found
// when scanning upward from 'start', wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW:0] pos;

    // Scanning from the far end lets the nearest hit overwrite later ones.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                idx   = pos[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// Packet-level round-robin arbiter merging handler upload streams onto the
// command processor's single upload port through a registered output beat.
module upload_arbiter
    import upload_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              ch_upload_req,
    input  logic [NUM_CH-1:0]              ch_upload_valid,
    input  logic [NUM_CH*DATA_W-1:0]       ch_upload_data,
    input  logic [NUM_CH*UPLOAD_SRC_W-1:0] ch_upload_source,
    output logic [NUM_CH-1:0]              ch_upload_ready,
    output logic                           upload_req,
    output logic                           upload_valid,
    output logic [DATA_W-1:0]              upload_data,
    output logic [UPLOAD_SRC_W-1:0]        upload_source,
    input  logic                           upload_ready,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy,
    output logic                           timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [IDX_W-1:0]         grant_id_q, grant_id_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic [UPLOAD_SRC_W-1:0]  out_source_q, out_source_d;
    logic                     busy_q, busy_d;

    logic [DATA_W-1:0]        data_arr [NUM_CH];
    logic [UPLOAD_SRC_W-1:0]  src_arr  [NUM_CH];
    logic [IDX_W-1:0]         rr_start, pick_idx;
    logic                     pick_found;
    logic                     in_grant, g_req, g_valid, ready_raw;
    logic                     accept, stall, timeout_hit, pkt_end;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            data_arr[i] = ch_upload_data[i*DATA_W +: DATA_W];
            src_arr[i]  = ch_upload_source[i*UPLOAD_SRC_W +: UPLOAD_SRC_W];
        end
    end

    assign rr_start = (last_grant_q == IDX_W'(NUM_CH - 1)) ? '0 : last_grant_q + 1'b1;

    rr_pick #(.N(NUM_CH)) u_rr_pick (
        .req   (ch_upload_req),
        .start (rr_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Granted-channel handshake; ready_raw never depends on the timeout so no loop forms.
    always_comb begin
        in_grant    = (state_q == GRANT);
        g_req       = ch_upload_req[grant_id_q];
        g_valid     = ch_upload_valid[grant_id_q];
        ready_raw   = !out_valid_q || upload_ready;
        accept      = in_grant && g_valid && ready_raw;
        stall       = in_grant && g_req && !accept;
        timeout_hit = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == CNT_LAST);
        pkt_end     = in_grant && !g_req && !g_valid;
    end

    always_comb begin
        out_valid_d  = accept || (out_valid_q && !upload_ready);
        out_data_d   = accept ? data_arr[grant_id_q] : out_data_q;
        out_source_d = accept ? src_arr[grant_id_q] : out_source_q;
    end

    // Next-state logic; the exit path picks DRAIN only if a beat will still be held.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = GRANT;
                    grant_id_d   = pick_idx;
                    last_grant_d = pick_idx;
                    cnt_d        = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = '0;
                end else if (stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (pkt_end || timeout_hit) begin
                    state_d = out_valid_d ? DRAIN : GAP;
                end
            end
            DRAIN: begin
                if (out_valid_q && upload_ready) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GRANT) || (state_d == DRAIN);
    end

    always_comb begin
        ch_upload_ready = '0;
        if (in_grant && !timeout_hit) begin
            ch_upload_ready[grant_id_q] = ready_raw;
        end
        timeout_pulse = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_source_q <= out_source_d;
            busy_q       <= busy_d;
        end
    end

    assign upload_req    = busy_q;
    assign busy          = busy_q;
    assign upload_valid  = out_valid_q;
    assign upload_data   = out_data_q;
    assign upload_source = out_source_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter: a per-cycle vector table for arbitration,
// backpressure and drain, then hand sequences for timeout and mid-packet reset.
module tb_upload_arbiter;
    import upload_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_upload_req;
    logic [3:0]  ch_upload_valid;
    logic [31:0] ch_upload_data;
    logic [31:0] ch_upload_source;
    logic [3:0]  ch_upload_ready;
    logic        upload_req;
    logic        upload_valid;
    logic [7:0]  upload_data;
    logic [7:0]  upload_source;
    logic        upload_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ur;
        logic        eReq;
        logic        eValid;
        logic [7:0]  eData;
        logic [7:0]  eSrc;
        logic [3:0]  eRdy;
        logic        eBusy;
        logic [1:0]  eGid;
    } vec_t;

    vec_t vecs[$];

    upload_arbiter #(
        .NUM_CH(4),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ch_upload_req    (ch_upload_req),
        .ch_upload_valid  (ch_upload_valid),
        .ch_upload_data   (ch_upload_data),
        .ch_upload_source (ch_upload_source),
        .ch_upload_ready  (ch_upload_ready),
        .upload_req       (upload_req),
        .upload_valid     (upload_valid),
        .upload_data      (upload_data),
        .upload_source    (upload_source),
        .upload_ready     (upload_ready),
        .grant_id         (grant_id),
        .busy             (busy),
        .timeout_pulse    (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [3:0] req, input logic [3:0] valid,
                                   input logic [31:0] data, input logic ur,
                                   input logic eReq, input logic eValid,
                                   input logic [7:0] eData, input logic [7:0] eSrc,
                                   input logic [3:0] eRdy, input logic eBusy,
                                   input logic [1:0] eGid);
        vec_t v;
        v.req = req;   v.valid = valid;   v.data = data;   v.ur = ur;
        v.eReq = eReq; v.eValid = eValid; v.eData = eData; v.eSrc = eSrc;
        v.eRdy = eRdy; v.eBusy = eBusy;   v.eGid = eGid;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] valid,
                         input logic [31:0] data, input logic ur);
        ch_upload_req   = req;
        ch_upload_valid = valid;
        ch_upload_data  = data;
        upload_ready    = ur;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.req, v.valid, v.data, v.ur);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("vec%0d_ctrl", idx),
                 64'({upload_req, upload_valid, ch_upload_ready, busy, grant_id, timeout_pulse}),
                 64'({v.eReq, v.eValid, v.eRdy, v.eBusy, v.eGid, 1'b0}));
        if (v.eValid) begin
            checkVal($sformatf("vec%0d_data", idx),
                     64'({upload_data, upload_source}), 64'({v.eData, v.eSrc}));
        end
    endtask

    initial begin
        // Contention ch0/ch2 from reset: ch0 first, ch2's held valid is not consumed early
        vecs.push_back(mkVec(4'b0101, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        vecs.push_back(mkVec(4'b0101, 4'b0101, 32'h00C0_00B0, 1, 1, 0, 8'h00, 8'h00, 4'b0001, 1, 2'd0));
        vecs.push_back(mkVec(4'b0101, 4'b0101, 32'h00C0_00B1, 1, 1, 1, 8'hB0, SRC_UART, 4'b0001, 1, 2'd0));
        vecs.push_back(mkVec(4'b0100, 4'b0100, 32'h00C0_0000, 1, 1, 1, 8'hB1, SRC_UART, 4'b0001, 1, 2'd0));
        vecs.push_back(mkVec(4'b0100, 4'b0100, 32'h00C0_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        vecs.push_back(mkVec(4'b0100, 4'b0100, 32'h00C0_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        vecs.push_back(mkVec(4'b0100, 4'b0100, 32'h00C0_0000, 1, 1, 0, 8'h00, 8'h00, 4'b0100, 1, 2'd2));
        vecs.push_back(mkVec(4'b0100, 4'b0100, 32'h00C1_0000, 1, 1, 1, 8'hC0, SRC_DSM, 4'b0100, 1, 2'd2));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 1, 8'hC1, SRC_DSM, 4'b0100, 1, 2'd2));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd2));
        // Single channel ch1, three beats
        vecs.push_back(mkVec(4'b0010, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd2));
        vecs.push_back(mkVec(4'b0010, 4'b0010, 32'h0000_A100, 1, 1, 0, 8'h00, 8'h00, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0010, 4'b0010, 32'h0000_A200, 1, 1, 1, 8'hA1, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0010, 4'b0010, 32'h0000_A300, 1, 1, 1, 8'hA2, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 1, 8'hA3, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        // Backpressure on ch1 for five cycles with a stray ch2 valid
        vecs.push_back(mkVec(4'b0010, 4'b0100, 32'h00EE_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        vecs.push_back(mkVec(4'b0010, 4'b0110, 32'h00EE_D100, 1, 1, 0, 8'h00, 8'h00, 4'b0010, 1, 2'd1));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mkVec(4'b0010, 4'b0110, 32'h00EE_D200, 0, 1, 1, 8'hD1, SRC_SPI, 4'b0000, 1, 2'd1));
        end
        vecs.push_back(mkVec(4'b0010, 4'b0110, 32'h00EE_D200, 1, 1, 1, 8'hD1, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0010, 4'b0110, 32'h00EE_D300, 1, 1, 1, 8'hD2, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0100, 32'h00EE_0000, 1, 1, 1, 8'hD3, SRC_SPI, 4'b0010, 1, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        // Second ch0/ch2 tie: pointer now favours ch2
        vecs.push_back(mkVec(4'b0101, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd1));
        vecs.push_back(mkVec(4'b0101, 4'b0101, 32'h00E1_00F1, 1, 1, 0, 8'h00, 8'h00, 4'b0100, 1, 2'd2));
        vecs.push_back(mkVec(4'b0001, 4'b0001, 32'h0000_00F1, 1, 1, 1, 8'hE1, SRC_DSM, 4'b0100, 1, 2'd2));
        vecs.push_back(mkVec(4'b0001, 4'b0001, 32'h0000_00F1, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd2));
        vecs.push_back(mkVec(4'b0001, 4'b0001, 32'h0000_00F1, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd2));
        vecs.push_back(mkVec(4'b0001, 4'b0001, 32'h0000_00F1, 1, 1, 0, 8'h00, 8'h00, 4'b0001, 1, 2'd0));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 1, 8'hF1, SRC_UART, 4'b0001, 1, 2'd0));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        // ch3 packet ends with the processor stalled: DRAIN holds the beat
        vecs.push_back(mkVec(4'b1000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd0));
        vecs.push_back(mkVec(4'b1000, 4'b1000, 32'h9100_0000, 1, 1, 0, 8'h00, 8'h00, 4'b1000, 1, 2'd3));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 0, 1, 1, 8'h91, SRC_I2C, 4'b0000, 1, 2'd3));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 0, 1, 1, 8'h91, SRC_I2C, 4'b0000, 1, 2'd3));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 1, 8'h91, SRC_I2C, 4'b0000, 1, 2'd3));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd3));
        vecs.push_back(mkVec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 2'd3));

        ch_upload_source = {SRC_I2C, SRC_DSM, SRC_SPI, SRC_UART};
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset_state",
                 64'({upload_req, upload_valid, upload_data, upload_source, ch_upload_ready,
                      grant_id, busy, timeout_pulse}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // Timeout: ch3 stalls with req high; ch0 waits and wins after GAP + IDLE
        $display("[TB] timeout sequence");
        drive(4'b1000, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checkVal("to_idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        drive(4'b1001, 4'b0000, 32'h0, 1'b1);
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            checkVal($sformatf("to_pulse_s%0d", s), 64'(timeout_pulse), 64'(s == 16));
            checkVal($sformatf("to_rdy_s%0d", s), 64'({ch_upload_ready, busy, grant_id}),
                     64'({(s == 16) ? 4'b0000 : 4'b1000, 1'b1, 2'd3}));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkVal("to_gap", 64'({upload_req, busy, timeout_pulse, ch_upload_ready}), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("to_idle", 64'({upload_req, busy, ch_upload_ready}), 64'(0));
        @(posedge clk);
        #1;
        drive(4'b1001, 4'b0001, 32'h0000_0055, 1'b0);
        @(negedge clk);
        checkVal("to_regrant_ch0", 64'({busy, grant_id, ch_upload_ready}), 64'({1'b1, 2'd0, 4'b0001}));
        @(posedge clk);
        #1;

        // Reset while a beat is pending at the output
        $display("[TB] reset mid-packet sequence");
        drive(4'b1101, 4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        checkVal("rst_pending_beat", 64'({upload_valid, upload_data, upload_source}),
                 64'({1'b1, 8'h55, SRC_UART}));
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rst_async",
                 64'({upload_req, upload_valid, upload_data, upload_source, ch_upload_ready,
                      grant_id, busy, timeout_pulse}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rst_first_grant", 64'({busy, grant_id, ch_upload_ready}), 64'({1'b1, 2'd0, 4'b0001}));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Parametrised, packet-level upload arbiter between the peripheral handlers (UART, SPI, DSM, I2C, …) and `command_processor`'s single upload port. Each handler raises `upload_req` for the duration of a packet. The arbiter grants one channel at a time in round-robin order, holds the grant until that packet ends, and never interleaves bytes from different sources. A registered output stage, a packet-boundary gap and a stall timeout replace the previous OR/priority-mux merge.

## Interface
- `NUM_CH`, default 4: number of handler channels (2..8).
- `DATA_W`, default 8: data beat width.
- `TIMEOUT_CYCLES`, default 65535: stall cycles before a grant is forcibly revoked; 0 disables the timeout.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ch_upload_req` in NUM_CH: per-channel packet request.
- `ch_upload_valid` in NUM_CH: per-channel beat valid.
- `ch_upload_data` in NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `ch_upload_source` in NUM_CH*8: channel i occupies bits [i*8 +: 8].
- `ch_upload_ready` out NUM_CH: per-channel beat accept.
- `upload_req` out 1: to the processor `upload_req_in`.
- `upload_valid` out 1, `upload_data` out DATA_W, `upload_source` out 8: to the processor.
- `upload_ready` in 1: from the processor `upload_ready_out`.
- `grant_id` out $clog2(NUM_CH): index of the granted channel; valid while `busy`.
- `busy` out 1: a grant is active.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: the channel `grant_id` owns the port.
  - DRAIN: the grant has ended but the output register still holds a beat.
  - GAP: one cycle with `upload_req` low.
- IDLE: if any `ch_upload_req` is high, select the first requesting channel starting from `last_grant+1` (mod NUM_CH), register `grant_id`, update `last_grant`, and go to GRANT. `last_grant` resets to NUM_CH-1, so channel 0 wins first.
- GRANT:
  - `ch_upload_ready[grant_id]` = `!out_valid || upload_ready` (combinational). All other ready bits are 0.
  - A beat is accepted when ready and valid are both high on the granted channel. It loads `upload_data`, `upload_source` and `upload_valid` on the next edge.
  - Valid on non-granted channels is ignored and not consumed.
- Packet end: granted `req` low AND granted `valid` low. Then go to DRAIN if a beat is pending, else GAP.
- DRAIN: hold until the processor accepts the pending beat (`upload_valid && upload_ready`), then go to GAP.
- GAP: `upload_req` low for exactly one cycle, then IDLE. The next grant is evaluated in IDLE, so the minimum inter-packet spacing is GAP plus IDLE, i.e. 2 cycles.
- `upload_req` output is registered: high in GRANT and DRAIN, low in IDLE and GAP.
- Timeout:
  - A counter clears on every accepted beat and on entry to GRANT. It increments in GRANT while the granted `req` is high and no beat is accepted.
  - When the count reaches `TIMEOUT_CYCLES`: pulse `timeout_pulse`, drop the granted ready, and go to DRAIN or GAP.
  - The timed-out channel loses its turn: `last_grant` is already itself.
  - The counter is sized $clog2(TIMEOUT_CYCLES+1) bits.
- Simultaneous events: a new `req` from another channel during GRANT waits. A `req` from the granted channel that falls and rises in the same cycle it would end is treated as the end; the channel must re-arbitrate.
- Reset mid-packet: all state clears immediately. Any pending output beat is discarded.

## Timing
- Reset values: `upload_req`=0, `upload_valid`=0, `upload_data`=0, `upload_source`=0, `ch_upload_ready`=0, `grant_id`=0, `busy`=0, `timeout_pulse`=0.
- Request to grant: `req` high in cycle n, GRANT and `ch_upload_ready` high in n+1.
- Accepted beat to `upload_valid`: 1 cycle. Throughput is 1 beat per cycle while `upload_ready` stays high.
- Output register holds data/source stable while `upload_valid && !upload_ready`.
- `busy` = state is GRANT or DRAIN; registered.

## Structure
- Shared package `upload_pkg`:
  - FSM state enum {IDLE, GRANT, DRAIN, GAP}.
  - Source-ID constants (UART, SPI, DSM, I2C).
  - `UPLOAD_SRC_W` = 8.
- One sub-module: `rr_pick`, a combinational round-robin first-one search. Inputs: request vector and start pointer. Output: index and found flag.
- The top-level integration instantiates `upload_arbiter` with NUM_CH=4 in place of the OR merge.

## Test plan
- Single channel: ch1 req, 3 beats 0xA1, 0xA2, 0xA3 with `upload_ready`=1. Required: grant 1 cycle after req, outputs 0xA1..0xA3 on consecutive cycles with ch1's source, `upload_req` low for one GAP cycle after the packet.
- Contention: ch0 and ch2 req simultaneously, 2 beats each. Required: ch0 packet complete, GAP, then ch2 packet; no interleaving; next tie goes to ch2→ch0 order per the pointer.
- Backpressure: `upload_ready` low for 5 cycles mid-packet. Required: `upload_data` stable, `ch_upload_ready` low, no beat lost or duplicated.
- Timeout: TIMEOUT_CYCLES=16, ch3 holds req with no valid. Required: `timeout_pulse` in the 16th stalled cycle, release, and a waiting ch0 granted 2 cycles later.
- Reset mid-packet: assert `rst_n`=0 with a pending beat. Required: all outputs 0 asynchronously; after release ch0 is granted first.
- Stray valid: ch2 valid without req while ch1 is granted. Required: ch2 ready stays 0, and only ch1 data appears at the output.
